// File: rtl/ap3216c_pkg.sv
// AP3216C register map, configuration bytes and sequencer state encoding.
package ap3216c_pkg;

    localparam logic [7:0] SYS_CFG = 8'h00;
    localparam logic [7:0] ALS_L   = 8'h0C;
    localparam logic [7:0] ALS_H   = 8'h0D;
    localparam logic [7:0] PS_L    = 8'h0E;
    localparam logic [7:0] PS_H    = 8'h0F;

    localparam logic [7:0] CFG_SWRST     = 8'h04;
    localparam logic [7:0] CFG_ALS_PS_IR = 8'h03;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WR_RST    = 3'd1;
    localparam state_t ST_WAIT_RST  = 3'd2;
    localparam state_t ST_WR_MODE   = 3'd3;
    localparam state_t ST_WAIT_CONV = 3'd4;
    localparam state_t ST_RD        = 3'd5;
    localparam state_t ST_UPDATE    = 3'd6;

    // Result registers are contiguous, so the burst index maps straight onto them.
    function automatic logic [7:0] rd_addr(input logic [1:0] idx);
        return ALS_L + 8'(idx);
    endfunction

endpackage

// File: rtl/ap3216c_reader.sv
// Register-level sequencer for the AP3216C: configures the sensor, then loops
// reading the ALS/PS result registers and publishes them with a valid strobe.
module ap3216c_reader
    import ap3216c_pkg::*;
#(
    parameter int unsigned T_RST_CYC  = 10_000,
    parameter int unsigned T_CONV_CYC = 150_000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [7:0]  i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    input  logic [7:0]  i2c_data_r,
    output logic [15:0] als_data,
    output logic [9:0]  ps_data,
    output logic        ps_ovf,
    output logic        data_valid,
    output logic        i2c_err
);

    localparam int unsigned T_MAX = (T_RST_CYC > T_CONV_CYC) ? T_RST_CYC : T_CONV_CYC;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST_CYC - 1);
    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(T_CONV_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic             pending, pending_nxt;
    logic [7:0]       hold_als_l, hold_als_l_nxt;
    logic [7:0]       hold_als_h, hold_als_h_nxt;
    logic [3:0]       hold_ps_l, hold_ps_l_nxt;
    logic             hold_ovf_l, hold_ovf_l_nxt;

    logic             exec_nxt, rh_wl_nxt, ovf_nxt, valid_nxt, err_nxt;
    logic [7:0]       addr_nxt, data_w_nxt;
    logic [15:0]      als_nxt;
    logic [9:0]       ps_nxt;
    logic             xfer_done;

    // A done pulse only counts while our own transaction is in flight.
    assign xfer_done = pending & i2c_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            hold_als_l <= '0;
            hold_als_h <= '0;
            hold_ps_l  <= '0;
            hold_ovf_l <= 1'b0;
            i2c_exec   <= 1'b0;
            i2c_rh_wl  <= 1'b0;
            i2c_addr   <= '0;
            i2c_data_w <= '0;
            als_data   <= '0;
            ps_data    <= '0;
            ps_ovf     <= 1'b0;
            data_valid <= 1'b0;
            i2c_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            pending    <= pending_nxt;
            hold_als_l <= hold_als_l_nxt;
            hold_als_h <= hold_als_h_nxt;
            hold_ps_l  <= hold_ps_l_nxt;
            hold_ovf_l <= hold_ovf_l_nxt;
            i2c_exec   <= exec_nxt;
            i2c_rh_wl  <= rh_wl_nxt;
            i2c_addr   <= addr_nxt;
            i2c_data_w <= data_w_nxt;
            als_data   <= als_nxt;
            ps_data    <= ps_nxt;
            ps_ovf     <= ovf_nxt;
            data_valid <= valid_nxt;
            i2c_err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        pending_nxt    = pending;
        hold_als_l_nxt = hold_als_l;
        hold_als_h_nxt = hold_als_h;
        hold_ps_l_nxt  = hold_ps_l;
        hold_ovf_l_nxt = hold_ovf_l;
        exec_nxt       = 1'b0;
        rh_wl_nxt      = i2c_rh_wl;
        addr_nxt       = i2c_addr;
        data_w_nxt     = i2c_data_w;
        als_nxt        = als_data;
        ps_nxt         = ps_data;
        ovf_nxt        = ps_ovf;
        valid_nxt      = 1'b0;
        err_nxt        = i2c_err;

        if (xfer_done && i2c_ack) begin
            // NACK anywhere: drop the partial burst and re-initialise the sensor.
            pending_nxt    = 1'b0;
            err_nxt        = 1'b1;
            hold_als_l_nxt = '0;
            hold_als_h_nxt = '0;
            hold_ps_l_nxt  = '0;
            hold_ovf_l_nxt = 1'b0;
            idx_nxt        = '0;
            cnt_nxt        = '0;
            state_nxt      = ST_WAIT_RST;
        end else begin
            case (state)
                ST_IDLE: begin
                    exec_nxt    = 1'b1;
                    pending_nxt = 1'b1;
                    rh_wl_nxt   = 1'b0;
                    addr_nxt    = SYS_CFG;
                    data_w_nxt  = CFG_SWRST;
                    state_nxt   = ST_WR_RST;
                end
                ST_WR_RST: begin
                    if (xfer_done) begin
                        pending_nxt = 1'b0;
                        cnt_nxt     = '0;
                        state_nxt   = ST_WAIT_RST;
                    end
                end
                ST_WAIT_RST: begin
                    if (cnt == RST_LAST) begin
                        cnt_nxt     = '0;
                        exec_nxt    = 1'b1;
                        pending_nxt = 1'b1;
                        rh_wl_nxt   = 1'b0;
                        addr_nxt    = SYS_CFG;
                        data_w_nxt  = CFG_ALS_PS_IR;
                        state_nxt   = ST_WR_MODE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_WR_MODE: begin
                    if (xfer_done) begin
                        pending_nxt = 1'b0;
                        cnt_nxt     = '0;
                        state_nxt   = ST_WAIT_CONV;
                    end
                end
                ST_WAIT_CONV: begin
                    if (cnt == CONV_LAST) begin
                        cnt_nxt     = '0;
                        idx_nxt     = '0;
                        exec_nxt    = 1'b1;
                        pending_nxt = 1'b1;
                        rh_wl_nxt   = 1'b1;
                        addr_nxt    = rd_addr(2'd0);
                        data_w_nxt  = '0;
                        state_nxt   = ST_RD;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_RD: begin
                    if (xfer_done) begin
                        pending_nxt = 1'b0;
                        case (idx)
                            2'd0: hold_als_l_nxt = i2c_data_r;
                            2'd1: hold_als_h_nxt = i2c_data_r;
                            2'd2: begin
                                hold_ps_l_nxt  = i2c_data_r[3:0];
                                hold_ovf_l_nxt = i2c_data_r[6];
                            end
                            default: begin
                                // Last byte is used straight off the bus so results land one cycle after done.
                                als_nxt   = {hold_als_h, hold_als_l};
                                ps_nxt    = {i2c_data_r[5:0], hold_ps_l};
                                ovf_nxt   = hold_ovf_l | i2c_data_r[6];
                                valid_nxt = 1'b1;
                                err_nxt   = 1'b0;
                                state_nxt = ST_UPDATE;
                            end
                        endcase
                        if (idx != 2'd3) begin
                            idx_nxt     = idx + 2'd1;
                            exec_nxt    = 1'b1;
                            pending_nxt = 1'b1;
                            addr_nxt    = rd_addr(idx + 2'd1);
                        end
                    end
                end
                ST_UPDATE: begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = ST_WAIT_CONV;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ap3216c_reader.sv
// Directed bench for ap3216c_reader with a fixed-latency I2C driver model.
module tb_ap3216c_reader;
    import ap3216c_pkg::*;

    localparam int T_RST   = 20;
    localparam int T_CONV  = 50;
    localparam int BFM_LAT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i2c_exec, i2c_rh_wl;
    logic [7:0]  i2c_addr, i2c_data_w;
    logic        i2c_done = 1'b0;
    logic        i2c_ack = 1'b0;
    logic [7:0]  i2c_data_r = 8'h00;
    logic [15:0] als_data;
    logic [9:0]  ps_data;
    logic        ps_ovf, data_valid, i2c_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         bfm_cnt = 0;
    logic [7:0] bfm_addr = 8'h00;
    logic       bfm_rh = 1'b0;
    logic [7:0] rb [4];
    bit         nack_armed = 1'b0;
    logic [7:0] nack_addr = 8'h00;

    bit         outstanding = 1'b0;
    logic [7:0] p_addr = 8'h00;
    logic       p_rh = 1'b0;

    bit         exec_now = 1'b0;
    int         exec_cyc = 0;
    logic [7:0] exec_addr = 8'h00;
    logic [7:0] exec_wdata = 8'h00;
    logic       exec_rh = 1'b0;
    int         last_done = 0;
    int         dv_cyc = 0;
    int         ref_cyc = 0;

    int         b_cyc [4];
    logic [7:0] b_addr [4];
    logic       b_rh [4];
    int         b_done [4];

    ap3216c_reader #(
        .T_RST_CYC (T_RST),
        .T_CONV_CYC(T_CONV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i2c_exec  (i2c_exec),
        .i2c_rh_wl (i2c_rh_wl),
        .i2c_addr  (i2c_addr),
        .i2c_data_w(i2c_data_w),
        .i2c_done  (i2c_done),
        .i2c_ack   (i2c_ack),
        .i2c_data_r(i2c_data_r),
        .als_data  (als_data),
        .ps_data   (ps_data),
        .ps_ovf    (ps_ovf),
        .data_valid(data_valid),
        .i2c_err   (i2c_err)
    );

    always #5 clk = ~clk;

    // One cycle: driver model, protocol watch, event capture; all at the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        exec_now   = 1'b0;
        i2c_done   = 1'b0;
        i2c_ack    = 1'b0;
        i2c_data_r = 8'h00;
        if (bfm_cnt > 0) begin
            bfm_cnt--;
            if (bfm_cnt == 0) begin
                i2c_done  = 1'b1;
                last_done = cyc;
                if (bfm_rh) i2c_data_r = rb[bfm_addr[1:0]];
                if (nack_armed && bfm_rh && bfm_addr == nack_addr) begin
                    i2c_ack    = 1'b1;
                    nack_armed = 1'b0;
                end
            end
        end
        if (data_valid) dv_cyc = cyc;
        if (i2c_exec) begin
            total++;
            if (outstanding) begin
                bad++;
                $display("FAIL proto_exec_overlap cyc=%0d got=exec_while_pending want=no_exec", cyc);
            end
            outstanding = 1'b1;
            p_addr      = i2c_addr;
            p_rh        = i2c_rh_wl;
            bfm_cnt     = BFM_LAT;
            bfm_addr    = i2c_addr;
            bfm_rh      = i2c_rh_wl;
            exec_now    = 1'b1;
            exec_cyc    = cyc;
            exec_addr   = i2c_addr;
            exec_wdata  = i2c_data_w;
            exec_rh     = i2c_rh_wl;
        end else if (outstanding) begin
            total++;
            if ({i2c_rh_wl, i2c_addr} !== {p_rh, p_addr}) begin
                bad++;
                $display("FAIL proto_hold cyc=%0d got=%b/%h want=%b/%h", cyc, i2c_rh_wl, i2c_addr, p_rh, p_addr);
            end
        end
        if (i2c_done) outstanding = 1'b0;
    endtask

    task automatic wait_exec();
        int n = 0;
        while (n < 200) begin
            step();
            n++;
            if (exec_now) break;
        end
        total++;
        if (!exec_now) begin
            bad++;
            $display("FAIL exec_timeout cyc=%0d got=none want=i2c_exec", cyc);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 20) begin
            step();
            n++;
            if (i2c_done) break;
        end
        total++;
        if (!i2c_done) begin
            bad++;
            $display("FAIL done_timeout cyc=%0d got=none want=i2c_done", cyc);
        end
    endtask

    task automatic do_burst();
        for (int k = 0; k < 4; k++) begin
            wait_exec();
            b_cyc[k]  = exec_cyc;
            b_addr[k] = exec_addr;
            b_rh[k]   = exec_rh;
            wait_done();
            b_done[k] = last_done;
        end
    endtask

    task automatic test_reset();
        int rel;
        rst = 1'b1;
        repeat (3) step();
        total++;
        if ({als_data, ps_data, ps_ovf, data_valid, i2c_err, i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w} !== '0) begin
            bad++;
            $display("FAIL reset_values als=%h ps=%h ovf=%b dv=%b err=%b exec=%b want all 0",
                     als_data, ps_data, ps_ovf, data_valid, i2c_err, i2c_exec);
        end
        rst = 1'b0;
        rel = cyc;
        wait_exec();
        total++;
        if (exec_cyc != rel + 1 || {exec_rh, exec_addr, exec_wdata} !== {1'b0, SYS_CFG, CFG_SWRST}) begin
            bad++;
            $display("FAIL reset_first_write cyc=%0d rh/addr/data=%b/%h/%h want cyc=%0d 0/00/04",
                     exec_cyc, exec_rh, exec_addr, exec_wdata, rel + 1);
        end
    endtask

    task automatic test_startup();
        int d;
        wait_done();
        d = last_done;
        wait_exec();
        total++;
        if (exec_cyc != d + T_RST + 1 || {exec_rh, exec_addr, exec_wdata} !== {1'b0, SYS_CFG, CFG_ALS_PS_IR}) begin
            bad++;
            $display("FAIL startup_mode_write cyc=%0d rh/addr/data=%b/%h/%h want cyc=%0d 0/00/03",
                     exec_cyc, exec_rh, exec_addr, exec_wdata, d + T_RST + 1);
        end
        wait_done();
        d = last_done;
        do_burst();
        total++;
        if (b_cyc[0] != d + T_CONV + 1) begin
            bad++;
            $display("FAIL startup_conv_gap got=%0d want=%0d", b_cyc[0], d + T_CONV + 1);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (b_rh[k] !== 1'b1 || b_addr[k] !== 8'(ALS_L + k) || (k > 0 && b_cyc[k] != b_done[k-1] + 1)) begin
                bad++;
                $display("FAIL startup_read%0d rh/addr=%b/%h cyc=%0d want 1/%h", k, b_rh[k], b_addr[k], b_cyc[k], 8'(ALS_L + k));
            end
        end
        total++;
        if (data_valid !== 1'b0 || als_data !== 16'h0000) begin
            bad++;
            $display("FAIL startup_early_valid dv=%b als=%h want 0/0000", data_valid, als_data);
        end
    endtask

    task automatic test_decode();
        step();
        total++;
        if (data_valid !== 1'b1 || dv_cyc != b_done[3] + 1 || als_data !== 16'h1234 || ps_data !== 10'h3FA
            || ps_ovf !== 1'b1 || i2c_err !== 1'b0) begin
            bad++;
            $display("FAIL decode dv=%b als=%h ps=%h ovf=%b err=%b want 1/1234/3fa/1/0", data_valid, als_data, ps_data, ps_ovf, i2c_err);
        end
        ref_cyc = cyc;
        step();
        total++;
        if (data_valid !== 1'b0) begin
            bad++;
            $display("FAIL decode_strobe_width dv=%b want 0", data_valid);
        end
    endtask

    task automatic test_loop();
        rb[0] = 8'h78; rb[1] = 8'h56; rb[2] = 8'h05; rb[3] = 8'h02;
        do_burst();
        total++;
        if (b_cyc[0] != ref_cyc + T_CONV + 1 || b_addr[0] !== ALS_L || b_rh[0] !== 1'b1) begin
            bad++;
            $display("FAIL loop_restart cyc=%0d addr=%h rh=%b want cyc=%0d 0c 1", b_cyc[0], b_addr[0], b_rh[0], ref_cyc + T_CONV + 1);
        end
        total++;
        if (als_data !== 16'h1234 || ps_data !== 10'h3FA || ps_ovf !== 1'b1 || data_valid !== 1'b0) begin
            bad++;
            $display("FAIL loop_hold als=%h ps=%h ovf=%b dv=%b want 1234/3fa/1/0", als_data, ps_data, ps_ovf, data_valid);
        end
        step();
        total++;
        if (data_valid !== 1'b1 || als_data !== 16'h5678 || ps_data !== 10'h025 || ps_ovf !== 1'b0) begin
            bad++;
            $display("FAIL loop_decode dv=%b als=%h ps=%h ovf=%b want 1/5678/025/0", data_valid, als_data, ps_data, ps_ovf);
        end
        step();
    endtask

    task automatic test_nack();
        int d;
        rb[0] = 8'h11; rb[1] = 8'h22; rb[2] = 8'h33; rb[3] = 8'h44;
        nack_addr  = ALS_H;
        nack_armed = 1'b1;
        wait_exec();
        wait_done();
        wait_exec();
        wait_done();
        d = last_done;
        step();
        total++;
        if (i2c_err !== 1'b1 || als_data !== 16'h5678 || ps_data !== 10'h025 || ps_ovf !== 1'b0 || data_valid !== 1'b0) begin
            bad++;
            $display("FAIL nack_flag err=%b als=%h ps=%h ovf=%b dv=%b want 1/5678/025/0/0", i2c_err, als_data, ps_data, ps_ovf, data_valid);
        end
        wait_exec();
        total++;
        if (exec_cyc != d + T_RST + 1 || {exec_rh, exec_addr, exec_wdata} !== {1'b0, SYS_CFG, CFG_ALS_PS_IR}) begin
            bad++;
            $display("FAIL nack_reinit cyc=%0d rh/addr/data=%b/%h/%h want cyc=%0d 0/00/03", exec_cyc, exec_rh, exec_addr, exec_wdata, d + T_RST + 1);
        end
        wait_done();
        d = last_done;
        do_burst();
        total++;
        if (b_cyc[0] != d + T_CONV + 1 || b_addr[0] !== ALS_L || b_addr[3] !== PS_H || i2c_err !== 1'b1) begin
            bad++;
            $display("FAIL nack_burst cyc=%0d a0=%h a3=%h err=%b want cyc=%0d 0c 0f 1", b_cyc[0], b_addr[0], b_addr[3], i2c_err, d + T_CONV + 1);
        end
        step();
        total++;
        if (data_valid !== 1'b1 || i2c_err !== 1'b0 || als_data !== 16'h2211 || ps_data !== 10'h043 || ps_ovf !== 1'b1) begin
            bad++;
            $display("FAIL nack_recover dv=%b err=%b als=%h ps=%h ovf=%b want 1/0/2211/043/1", data_valid, i2c_err, als_data, ps_data, ps_ovf);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        int e;
        int d;
        exec_addr = 8'h00;
        for (int k = 0; k < 3 && exec_addr !== PS_L; k++) wait_exec();
        e = exec_cyc;
        step();
        step();
        rst = 1'b1;
        outstanding = 1'b0;
        step();
        total++;
        if ({als_data, ps_data, ps_ovf, data_valid, i2c_err, i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w} !== '0) begin
            bad++;
            $display("FAIL midreset_values als=%h ps=%h ovf=%b addr=%h rh=%b want all 0", als_data, ps_data, ps_ovf, i2c_addr, i2c_rh_wl);
        end
        repeat (4) step();
        step();
        rst = 1'b0;
        wait_exec();
        total++;
        if (exec_cyc != e + 9 || {exec_rh, exec_addr, exec_wdata} !== {1'b0, SYS_CFG, CFG_SWRST}) begin
            bad++;
            $display("FAIL midreset_restart cyc=%0d rh/addr/data=%b/%h/%h want cyc=%0d 0/00/04", exec_cyc, exec_rh, exec_addr, exec_wdata, e + 9);
        end
        wait_done();
        d = last_done;
        wait_exec();
        total++;
        if (exec_cyc != d + T_RST + 1 || {exec_rh, exec_addr, exec_wdata} !== {1'b0, SYS_CFG, CFG_ALS_PS_IR}) begin
            bad++;
            $display("FAIL midreset_mode cyc=%0d rh/addr/data=%b/%h/%h want cyc=%0d 0/00/03", exec_cyc, exec_rh, exec_addr, exec_wdata, d + T_RST + 1);
        end
        wait_done();
        d = last_done;
        do_burst();
        total++;
        if (b_cyc[0] != d + T_CONV + 1 || b_addr[2] !== PS_L || b_cyc[3] != b_done[2] + 1) begin
            bad++;
            $display("FAIL midreset_burst cyc=%0d a2=%h want cyc=%0d 0e", b_cyc[0], b_addr[2], d + T_CONV + 1);
        end
        step();
        total++;
        if (data_valid !== 1'b1 || als_data !== 16'h2211 || ps_data !== 10'h043 || ps_ovf !== 1'b1) begin
            bad++;
            $display("FAIL midreset_decode dv=%b als=%h ps=%h ovf=%b want 1/2211/043/1", data_valid, als_data, ps_data, ps_ovf);
        end
    endtask

    initial begin
        rb[0] = 8'h34; rb[1] = 8'h12; rb[2] = 8'h4A; rb[3] = 8'h3F;
        test_reset();
        test_startup();
        test_decode();
        test_loop();
        test_nack();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
